// File: rtl/regfile_seq_pkg.sv
// Shared constants for the register-file instruction sequencer: field positions,
// opcodes and FSM state encodings.
package regfile_seq_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned INSTR_W = 16;

    localparam int unsigned OP_MSB  = 15;
    localparam int unsigned OP_LSB  = 12;
    localparam int unsigned RD_MSB  = 11;
    localparam int unsigned RD_LSB  = 8;
    localparam int unsigned RS1_MSB = 7;
    localparam int unsigned RS1_LSB = 4;
    localparam int unsigned RS2_MSB = 3;
    localparam int unsigned RS2_LSB = 0;
    localparam int unsigned IMM_MSB = 7;
    localparam int unsigned IMM_LSB = 0;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_MOV = 4'd6;
    localparam logic [3:0] OP_LDI = 4'd7;
    localparam logic [3:0] OP_CMP = 4'd8;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_READ = 2'd1;
    localparam state_t S_EXEC = 2'd2;
    localparam state_t S_WB   = 2'd3;

    // NOP and the illegal opcodes leave result and flags untouched.
    function automatic logic op_sets_flags(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_CMP);
    endfunction

endpackage

// File: rtl/seq_alu8.sv
// Combinational 8-bit ALU for the sequencer; carry doubles as borrow for SUB/CMP.
module seq_alu8
    import regfile_seq_pkg::*;
(
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] y,
    output logic              carry,
    output logic              zero,
    output logic              writes_rd
);

    logic [DATA_W:0] sum;

    always_comb begin
        sum   = '0;
        y     = '0;
        carry = 1'b0;
        case (op)
            OP_ADD: begin
                sum   = {1'b0, a} + {1'b0, b};
                y     = sum[DATA_W-1:0];
                carry = sum[DATA_W];
            end
            // Bit 8 of the 9-bit difference is set exactly when a < b.
            OP_SUB, OP_CMP: begin
                sum   = {1'b0, a} - {1'b0, b};
                y     = sum[DATA_W-1:0];
                carry = sum[DATA_W];
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_MOV:  y = a;
            OP_LDI:  y = imm;
            default: y = '0;
        endcase
    end

    assign zero      = (y == '0);
    assign writes_rd = (op >= OP_ADD) && (op <= OP_LDI);

endmodule

// File: rtl/regfile_sequencer.sv
// Four-cycle IDLE/READ/EXEC/WB sequencer driving a 16x8 register file from
// latched 16-bit instructions.
module regfile_sequencer
    import regfile_seq_pkg::*;
(
    input  logic                clk,
    input  logic                Reset,
    input  logic                instr_valid,
    input  logic [INSTR_W-1:0]  instr,
    output logic                instr_ready,
    output logic                RegFileRead,
    output logic                RegFileWrite,
    output logic [ADDR_W-1:0]   Source1,
    output logic [ADDR_W-1:0]   Source2,
    output logic [ADDR_W-1:0]   Destin,
    output logic [DATA_W-1:0]   Datain,
    input  logic [DATA_W-1:0]   Dataout1,
    input  logic [DATA_W-1:0]   Dataout2,
    output logic                done,
    output logic                illegal,
    output logic [DATA_W-1:0]   result,
    output logic                flag_z,
    output logic                flag_c
);

    state_t              state_q, state_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [DATA_W-1:0]   opa_q, opa_d;
    logic [DATA_W-1:0]   opb_q, opb_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                flag_z_q, flag_z_d;
    logic                flag_c_q, flag_c_d;
    logic                done_q, done_d;
    logic                illegal_q, illegal_d;

    logic [3:0]          op;
    logic [DATA_W-1:0]   alu_y;
    logic                alu_carry;
    logic                alu_zero;
    logic                alu_writes_rd;

    assign op = instr_q[OP_MSB:OP_LSB];

    seq_alu8 u_alu (
        .op        (op),
        .a         (opa_q),
        .b         (opb_q),
        .imm       (instr_q[IMM_MSB:IMM_LSB]),
        .y         (alu_y),
        .carry     (alu_carry),
        .zero      (alu_zero),
        .writes_rd (alu_writes_rd)
    );

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        result_d  = result_q;
        flag_z_d  = flag_z_q;
        flag_c_d  = flag_c_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                opa_d   = Dataout1;
                opb_d   = Dataout2;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (op_sets_flags(op)) begin
                    result_d = alu_y;
                    flag_z_d = alu_zero;
                    flag_c_d = alu_carry;
                end
                state_d = S_WB;
            end
            S_WB: begin
                done_d    = 1'b1;
                illegal_d = (op > OP_CMP);
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            instr_q   <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            result_q  <= '0;
            flag_z_q  <= 1'b0;
            flag_c_q  <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            result_q  <= result_d;
            flag_z_q  <= flag_z_d;
            flag_c_q  <= flag_c_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    // Strobes are masked by Reset so an aborted WB never commits a write.
    assign instr_ready  = (state_q == S_IDLE);
    assign RegFileRead  = (state_q == S_READ) && !Reset;
    assign RegFileWrite = (state_q == S_WB) && alu_writes_rd && !Reset;

    assign Source1 = instr_q[RS1_MSB:RS1_LSB];
    assign Source2 = instr_q[RS2_MSB:RS2_LSB];
    assign Destin  = instr_q[RD_MSB:RD_LSB];
    assign Datain  = result_q;

    assign done    = done_q;
    assign illegal = illegal_q;
    assign result  = result_q;
    assign flag_z  = flag_z_q;
    assign flag_c  = flag_c_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: directed program plus random instructions checked
// against an instruction-level model of the register file and flags.
module tb_regfile_sequencer;

    logic        clk;
    logic        Reset;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        RegFileRead;
    logic        RegFileWrite;
    logic [3:0]  Source1;
    logic [3:0]  Source2;
    logic [3:0]  Destin;
    logic [7:0]  Datain;
    logic [7:0]  Dataout1;
    logic [7:0]  Dataout2;
    logic        done;
    logic        illegal;
    logic [7:0]  result;
    logic        flag_z;
    logic        flag_c;

    int checks = 0;
    int errors = 0;

    // Register file seen by the DUT, and the model's expected contents.
    logic [7:0] rf     [16];
    logic [7:0] ref_rf [16];
    logic [7:0] exp_result;
    logic       exp_z;
    logic       exp_c;

    regfile_sequencer dut (
        .clk          (clk),
        .Reset        (Reset),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_ready  (instr_ready),
        .RegFileRead  (RegFileRead),
        .RegFileWrite (RegFileWrite),
        .Source1      (Source1),
        .Source2      (Source2),
        .Destin       (Destin),
        .Datain       (Datain),
        .Dataout1     (Dataout1),
        .Dataout2     (Dataout2),
        .done         (done),
        .illegal      (illegal),
        .result       (result),
        .flag_z       (flag_z),
        .flag_c       (flag_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign Dataout1 = rf[Source1];
    assign Dataout2 = rf[Source2];

    always @(posedge clk) begin
        if (RegFileWrite) rf[Destin] <= Datain;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_rf(input string tag);
        for (int r = 0; r < 16; r++) begin
            check($sformatf("%s_r%0d", tag, r), {24'd0, rf[r]}, {24'd0, ref_rf[r]});
        end
    endtask

    // Instruction-level model: returns whether rd is written and whether it is illegal.
    task automatic model(input logic [15:0] ins, output bit wr, output bit ill);
        int op, rd, a, b, imm, y;
        bit c;
        op  = int'(ins[15:12]);
        rd  = int'(ins[11:8]);
        a   = int'(ref_rf[ins[7:4]]);
        b   = int'(ref_rf[ins[3:0]]);
        imm = int'(ins[7:0]);
        wr  = (op >= 1) && (op <= 7);
        ill = (op >= 9);
        y   = 0;
        c   = 1'b0;
        case (op)
            1: begin y = (a + b) % 256; c = (a + b) > 255; end
            2, 8: begin y = (a - b + 256) % 256; c = a < b; end
            3: y = a & b;
            4: y = a | b;
            5: y = a ^ b;
            6: y = a;
            7: y = imm;
            default: y = 0;
        endcase
        if (op >= 1 && op <= 8) begin
            exp_result = 8'(y);
            exp_z      = (y == 0);
            exp_c      = c;
        end
        if (wr) ref_rf[rd] = 8'(y);
    endtask

    // Called at a negedge with the sequencer idle; returns at the negedge of the done cycle.
    task automatic run_instr(input logic [15:0] ins, input bit keep_valid);
        bit wr, ill;
        check("ready_at_accept", {31'd0, instr_ready}, 32'd1);
        instr_valid = 1'b1;
        instr       = ins;
        model(ins, wr, ill);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check($sformatf("ready_c%0d", c), {31'd0, instr_ready}, {31'd0, c == 4});
            check($sformatf("done_c%0d", c), {31'd0, done}, {31'd0, c == 4});
            check($sformatf("illegal_c%0d", c), {31'd0, illegal}, {31'd0, (c == 4) && ill});
            check($sformatf("rd_strobe_c%0d", c), {31'd0, RegFileRead}, {31'd0, c == 1});
            check($sformatf("wr_strobe_c%0d", c), {31'd0, RegFileWrite},
                  {31'd0, (c == 3) && wr});
            if (c == 1) begin
                check("src1", {28'd0, Source1}, {28'd0, ins[7:4]});
                check("src2", {28'd0, Source2}, {28'd0, ins[3:0]});
                check("destin", {28'd0, Destin}, {28'd0, ins[11:8]});
            end
            if (c < 4) begin
                if (keep_valid) instr = 16'($urandom);
                else instr_valid = 1'b0;
            end
        end
        check("result", {24'd0, result}, {24'd0, exp_result});
        check("flag_z", {31'd0, flag_z}, {31'd0, exp_z});
        check("flag_c", {31'd0, flag_c}, {31'd0, exp_c});
        check_rf("rf");
    endtask

    initial begin
        Reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        exp_result  = 8'h00;
        exp_z       = 1'b0;
        exp_c       = 1'b0;
        for (int r = 0; r < 16; r++) begin
            rf[r]     = 8'h00;
            ref_rf[r] = 8'h00;
        end
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, instr_ready}, 32'd1);
        check("rst_strobes", {30'd0, RegFileRead, RegFileWrite}, 32'd0);
        check("rst_addr", {20'd0, Source1, Source2, Destin}, 32'd0);
        check("rst_datain", {24'd0, Datain}, 32'd0);
        check("rst_pulses", {30'd0, done, illegal}, 32'd0);
        check("rst_result", {22'd0, result, flag_z, flag_c}, 32'd0);
        Reset = 1'b0;
        @(negedge clk);

        run_instr(16'h717F, 1'b0);               // LDI R1,0x7F
        run_instr(16'h7201, 1'b0);               // LDI R2,0x01
        run_instr(16'h1312, 1'b0);               // ADD R3,R1,R2
        check("plan_r3", {24'd0, rf[3]}, 32'h80);
        check("plan_zc_add", {30'd0, flag_z, flag_c}, 32'd0);
        run_instr(16'h74FF, 1'b0);               // LDI R4,0xFF
        run_instr(16'h1542, 1'b0);               // ADD R5,R4,R2
        check("plan_r5", {24'd0, rf[5]}, 32'h00);
        check("plan_zc_wrap", {30'd0, flag_z, flag_c}, 32'd3);
        run_instr(16'h2621, 1'b0);               // SUB R6,R2,R1
        check("plan_r6", {24'd0, rf[6]}, 32'h82);
        check("plan_zc_sub", {30'd0, flag_z, flag_c}, 32'd1);
        run_instr(16'h8011, 1'b0);               // CMP R1,R1
        check("plan_zc_cmp", {30'd0, flag_z, flag_c}, 32'd2);
        run_instr(16'hF312, 1'b0);               // illegal, rd=3
        run_instr(16'h7710, 1'b0);               // accepted in the done cycle
        for (int k = 0; k < 3; k++) run_instr(16'h1772, 1'b1);
        instr_valid = 1'b0;
        check("plan_r7", {24'd0, rf[7]}, 32'h13);

        // Reset during WB of LDI R9,0xAA.
        instr_valid = 1'b1;
        instr       = 16'h79AA;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        Reset = 1'b1;
        #1;
        check("wr_during_reset", {31'd0, RegFileWrite}, 32'd0);
        @(negedge clk);
        Reset = 1'b0;
        check("post_rst_ready", {31'd0, instr_ready}, 32'd1);
        check("post_rst_strobes", {30'd0, RegFileRead, RegFileWrite}, 32'd0);
        check("post_rst_addr", {20'd0, Source1, Source2, Destin}, 32'd0);
        check("post_rst_pulses", {30'd0, done, illegal}, 32'd0);
        check("post_rst_result", {22'd0, result, flag_z, flag_c}, 32'd0);
        check("plan_r9", {24'd0, rf[9]}, 32'h00);
        exp_result = 8'h00;
        exp_z      = 1'b0;
        exp_c      = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'd0, instr_ready}, 32'd1);
        check_rf("rf_after_rst");

        for (int k = 0; k < 60; k++) begin
            run_instr(16'($urandom), 1'($urandom_range(0, 1)));
        end
        instr_valid = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
